// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if: N byte-stream sources merged onto one stream toward the emitter
interface stream_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N*W-1:0] i_tdata;
  logic [N-1:0] i_tlast;
  logic [N-1:0] i_tvalid;
  logic [N-1:0] o_tready;
  logic [W-1:0] o_tdata;
  logic o_tlast;
  logic o_tvalid;
  logic i_tready;
  modport master (
    output i_tdata, i_tlast, i_tvalid, i_tready,
    input o_tready, o_tdata, o_tlast, o_tvalid
  );
  modport slave (
    input i_tdata, i_tlast, i_tvalid, i_tready,
    output o_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-atomic round-robin merge of N streams with registered output and stall watchdog
module stream_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic rst,
  stream_rr_arbiter_if.slave s,
  output logic [$clog2(N)-1:0] o_grant,
  output logic o_busy,
  output logic o_timeout
);
  localparam int GW = $clog2(N);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [GW-1:0] ptr, pick, nxt;
  logic [CW-1:0] stall_cnt;
  logic ready, take, stall, fire;
  // nearest requester at or after ptr, wrapping; scanned downward so the smallest offset wins
  always_comb begin
    pick = ptr;
    for (int i = N - 1; i >= 0; i--)
      if (s.i_tvalid[(int'(ptr) + i) % N]) pick = GW'((int'(ptr) + i) % N);
  end
  assign ready = state == LOCKED && (!s.o_tvalid || s.i_tready);
  assign take = ready && s.i_tvalid[o_grant];
  assign stall = !s.i_tvalid[o_grant];
  assign fire = TIMEOUT > 0 && state == LOCKED && stall && stall_cnt == LAST_CNT;
  assign nxt = o_grant == GW'(N - 1) ? '0 : o_grant + 1'b1;
  assign s.o_tready = ready ? N'(1) << o_grant : '0;
  assign o_busy = state == LOCKED;
  // output register: load an accepted beat, otherwise drain when downstream takes it
  always_ff @(posedge clk)
    if (rst) begin
      s.o_tvalid <= 1'b0;
      s.o_tdata <= '0;
      s.o_tlast <= 1'b0;
    end else if (take) begin
      s.o_tvalid <= 1'b1;
      s.o_tdata <= s.i_tdata[int'(o_grant) * W +: W];
      s.o_tlast <= s.i_tlast[o_grant];
    end else if (s.i_tready) s.o_tvalid <= 1'b0;
  // arbitration FSM: lock on a grant until tlast is accepted or the watchdog releases it
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      o_grant <= '0;
      stall_cnt <= '0;
      o_timeout <= 1'b0;
    end else if (state == IDLE) begin
      if (|s.i_tvalid) begin
        o_grant <= pick;
        stall_cnt <= '0;
        state <= LOCKED;
      end
    end else if (take && s.i_tlast[o_grant]) begin
      state <= IDLE;
      ptr <= nxt;
    end else if (fire) begin
      state <= IDLE;
      ptr <= nxt;
      o_timeout <= 1'b1;
    end else stall_cnt <= stall ? stall_cnt + 1'b1 : '0;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: vector table, directed corner sequences and randomized scoreboard run
module tb_stream_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] o_grant;
  logic o_busy, o_timeout;
  int n_cmp = 0;
  int n_bad = 0;
  stream_rr_arbiter_if #(.N(N), .W(W)) bus();
  stream_rr_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s(bus.slave),
    .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] tv, tl;
    logic [31:0] td;
    logic rdy, ov;
    logic [7:0] otd;
    logic otl, busy;
    logic [1:0] g;
    logic [3:0] tr;
  } vec_t;
  vec_t tbl[$];
  bit act[N];
  int bi[N], ln[N], sq[N];
  logic [3:0] acc;
  logic [8:0] q[$];
  int gq[$];
  int mown, mgr, mptr;
  logic pbusy;
  function automatic vec_t mk(logic [3:0] tv, logic [3:0] tl, logic [31:0] td, logic rdy,
                              logic ov, logic [7:0] otd, logic otl, logic busy, logic [1:0] g, logic [3:0] tr);
    return '{tv, tl, td, rdy, ov, otd, otl, busy, g, tr};
  endfunction
  function automatic int first_from(logic [3:0] v, int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  task automatic chk(string nm, logic [31:0] act_v, logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask
  task automatic step(logic [3:0] tv, logic [3:0] tl, logic [31:0] td, logic rdy, logic r);
    @(negedge clk);
    bus.i_tvalid = tv;
    bus.i_tlast = tl;
    bus.i_tdata = td;
    bus.i_tready = rdy;
    rst = r;
    #1;
  endtask
  task automatic chk_out(string nm, logic ov, logic [7:0] otd, logic otl, logic busy,
                         logic [1:0] g, logic [3:0] tr, logic tmo);
    chk({nm, ".o_tvalid"}, bus.o_tvalid, ov);
    chk({nm, ".o_tdata"}, bus.o_tdata, otd);
    chk({nm, ".o_tlast"}, bus.o_tlast, otl);
    chk({nm, ".o_busy"}, o_busy, busy);
    chk({nm, ".o_grant"}, o_grant, g);
    chk({nm, ".o_tready"}, bus.o_tready, tr);
    chk({nm, ".o_timeout"}, o_timeout, tmo);
  endtask
  task automatic do_reset();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < N; k++) begin
      act[k] = 0;
      bi[k] = 0;
      ln[k] = 1;
    end
    acc = '0;
    q.delete();
    mown = -1;
    mgr = 0;
    mptr = 0;
    pbusy = 1'b0;
  endtask
  // sources emit whole packets; the model says who owns the output and which beats must appear in order
  task automatic run(int cycles, bit fair);
    logic [3:0] tv, tl, exp_tr;
    logic [31:0] td;
    logic rdy;
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          sq[k]++;
          if (bi[k] == ln[k] - 1) act[k] = 0;
          else bi[k]++;
        end
        if (!act[k] && (fair || $urandom_range(0, 3) == 0)) begin
          act[k] = 1;
          bi[k] = 0;
          ln[k] = fair ? 2 : int'($urandom_range(1, 4));
        end
        tv[k] = act[k];
        tl[k] = act[k] ? (bi[k] == ln[k] - 1) : 1'($urandom);
        td[k*W +: W] = act[k] ? 8'((k << 6) | (sq[k] & 63)) : 8'($urandom);
      end
      rdy = fair || ((c % 50) >= 12 && $urandom_range(0, 3) != 0);
      step(tv, tl, td, rdy, 0);
      exp_tr = (mown >= 0 && (q.size() == 0 || rdy)) ? 4'(1 << mown) : 4'b0;
      chk("run.busy", o_busy, mown >= 0);
      chk("run.grant", o_grant, mgr);
      chk("run.tready", bus.o_tready, exp_tr);
      chk("run.ovalid", bus.o_tvalid, q.size() != 0);
      if (q.size() != 0) chk("run.obeat", {bus.o_tlast, bus.o_tdata}, q[0]);
      if (fair && o_busy && !pbusy) gq.push_back(int'(o_grant));
      pbusy = o_busy;
      if (q.size() != 0 && rdy) void'(q.pop_front());
      acc = '0;
      if (mown < 0) begin
        if (|tv) begin
          mown = first_from(tv, mptr);
          mgr = mown;
        end
      end else if (exp_tr[mown] && tv[mown]) begin
        q.push_back({tl[mown], td[mown*W +: W]});
        acc[mown] = 1'b1;
        if (tl[mown]) begin
          mptr = (mown + 1) % N;
          mown = -1;
        end
      end
    end
  endtask
  initial begin
    for (int k = 0; k < N; k++) sq[k] = 0;
    do_reset();
    chk_out("reset", 0, 8'h00, 0, 0, 0, 4'b0000, 0);
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h0041_0000, 1, 0, 8'h00, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h0041_0000, 1, 0, 8'h00, 0, 1, 2, 4'b0100));
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h0042_0000, 1, 1, 8'h41, 0, 1, 2, 4'b0100));
    tbl.push_back(mk(4'b0100, 4'b0100, 32'h0043_0000, 1, 1, 8'h42, 0, 1, 2, 4'b0100));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 8'h43, 1, 0, 2, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h43, 1, 0, 2, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_0010, 1, 0, 8'h43, 1, 0, 2, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_0010, 1, 0, 8'h43, 1, 1, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_0011, 1, 1, 8'h10, 0, 1, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_0012, 0, 1, 8'h11, 0, 1, 0, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_0012, 0, 1, 8'h11, 0, 1, 0, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_0012, 1, 1, 8'h11, 0, 1, 0, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0001, 32'h0000_0013, 1, 1, 8'h12, 0, 1, 0, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 8'h13, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h13, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1000, 4'b0000, 32'h3100_0000, 1, 0, 8'h13, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1000, 4'b0000, 32'h3100_0000, 1, 0, 8'h13, 1, 1, 3, 4'b1000));
    tbl.push_back(mk(4'b1001, 4'b1001, 32'h3200_0001, 1, 1, 8'h31, 0, 1, 3, 4'b1000));
    tbl.push_back(mk(4'b1001, 4'b1001, 32'h3300_0001, 1, 1, 8'h32, 1, 0, 3, 4'b0000));
    tbl.push_back(mk(4'b1001, 4'b1001, 32'h3300_0001, 1, 0, 8'h32, 1, 1, 0, 4'b0001));
    tbl.push_back(mk(4'b1000, 4'b1000, 32'h3300_0000, 1, 1, 8'h01, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b1000, 4'b1000, 32'h3300_0000, 1, 0, 8'h01, 1, 1, 3, 4'b1000));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 1, 8'h33, 1, 0, 3, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h33, 1, 0, 3, 4'b0000));
    foreach (tbl[i]) begin
      step(tbl[i].tv, tbl[i].tl, tbl[i].td, tbl[i].rdy, 0);
      chk_out($sformatf("vec%0d", i), tbl[i].ov, tbl[i].otd, tbl[i].otl, tbl[i].busy, tbl[i].g, tbl[i].tr, 0);
    end
    do_reset();
    step(4'b0010, 4'b0010, 32'h0000_7100, 1, 0);
    step(4'b0010, 4'b0010, 32'h0000_7100, 1, 0);
    chk("rm.grant1", o_grant, 1);
    step(4'b0100, 4'b0000, 32'h0081_0000, 1, 0);
    chk("rm.idle_gap", o_busy, 0);
    step(4'b0100, 4'b0000, 32'h0081_0000, 1, 0);
    chk("rm.grant2", o_grant, 2);
    step(4'b0100, 4'b0000, 32'h0082_0000, 1, 1);
    chk("rm.beat1", bus.o_tdata, 8'h81);
    step(4'b1010, 4'b1010, 32'h9300_9100, 1, 0);
    chk_out("rm.after_rst", 0, 8'h00, 0, 0, 0, 4'b0000, 0);
    step(4'b1010, 4'b1010, 32'h9300_9100, 1, 0);
    chk("rm.restart_grant", o_grant, 1);
    chk("rm.no_stale_beat", bus.o_tvalid, 0);
    step(4'b1000, 4'b1000, 32'h9300_0000, 1, 0);
    chk("rm.first_beat", {bus.o_tvalid, bus.o_tlast, bus.o_tdata}, {1'b1, 1'b1, 8'h91});
    do_reset();
    step(4'b0110, 4'b0100, 32'h0066_5500, 1, 0);
    step(4'b0110, 4'b0100, 32'h0066_5500, 1, 0);
    chk("wd.grant", o_grant, 1);
    chk("wd.tready", bus.o_tready, 4'b0010);
    for (int i = 0; i < TO; i++) begin
      step(4'b0100, 4'b0100, 32'h0066_0000, 1, 0);
      chk("wd.locked", o_busy, 1);
      chk("wd.no_timeout_yet", o_timeout, 0);
      if (i == 0) chk("wd.partial_beat", {bus.o_tvalid, bus.o_tlast, bus.o_tdata}, {1'b1, 1'b0, 8'h55});
    end
    step(4'b0100, 4'b0100, 32'h0066_0000, 1, 0);
    chk("wd.released", o_busy, 0);
    chk("wd.timeout_set", o_timeout, 1);
    step(4'b0100, 4'b0100, 32'h0066_0000, 1, 0);
    chk("wd.next_grant", o_grant, 2);
    chk("wd.next_tready", bus.o_tready, 4'b0100);
    step(0, 0, 0, 1, 0);
    chk("wd.next_beat", {bus.o_tvalid, bus.o_tlast, bus.o_tdata}, {1'b1, 1'b1, 8'h66});
    repeat (5) step(0, 0, 0, 1, 0);
    chk("wd.sticky", o_timeout, 1);
    do_reset();
    gq.delete();
    run(40, 1);
    if (gq.size() >= 5) for (int i = 0; i < 5; i++) chk($sformatf("fair.order%0d", i), gq[i], i % N);
    else chk("fair.grant_count", gq.size(), 5);
    do_reset();
    run(2000, 0);
    chk("rand.no_timeout", o_timeout, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Packet-atomic round-robin arbiter that merges N byte-wide AXI-stream message sources onto the single stream feeding the UART emitter. Once an input is granted, it keeps the grant until a beat with tlast is transferred, so messages from different cores never interleave. The block sits between the per-core message sources and the emitter. It has a registered output stage and a stall watchdog that releases a hung source.

## Interface
- N, default 4: number of input streams; legal range 2..32.
- W, default 8: tdata width in bits.
- TIMEOUT, default 0: consecutive stall cycles of the granted input before forced release; 0 disables the watchdog.
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- i_tdata, in, N*W: input data; input k occupies bits [k*W +: W].
- i_tlast, in, N: per-input end of packet.
- i_tvalid, in, N: per-input valid.
- o_tready, out, N: per-input ready; at most one bit is set at any time.
- o_tdata, out, W: merged output data, registered.
- o_tlast, out, 1: merged end of packet, registered.
- o_tvalid, out, 1: merged valid, registered.
- i_tready, in, 1: downstream ready from the emitter.
- o_grant, out, clog2(N): index of the current or last granted input.
- o_busy, out, 1: high while in LOCKED.
- o_timeout, out, 1: sticky flag, set by any watchdog release and cleared only by rst.

## Operation
- States: IDLE and LOCKED.
- **IDLE**
  - All o_tready bits are 0.
  - If any i_tvalid is set, select the first set bit searching from index ptr upward, wrapping modulo N.
  - Register that index into o_grant, clear the stall counter and go to LOCKED.
  - Otherwise stay in IDLE.
- **LOCKED**
  - o_tready[o_grant] = (!o_tvalid || i_tready); all other o_tready bits are 0.
  - The output register loads the granted input's tdata/tlast whenever o_tready[o_grant] && i_tvalid[o_grant].
  - A transfer with i_tlast set returns to IDLE and sets ptr = (o_grant+1) mod N.
- **Output register**
  - o_tvalid is set on load.
  - o_tvalid is cleared when i_tready && o_tvalid and no new load happens in the same cycle.
  - A simultaneous drain and load keeps o_tvalid = 1 with the new data.
  - o_tdata/o_tlast hold their value while o_tvalid && !i_tready (AXI stability).
- **Watchdog** (TIMEOUT > 0)
  - In LOCKED, the stall counter increments on every cycle with !i_tvalid[o_grant] and clears on any cycle with i_tvalid[o_grant] high.
  - When it reaches TIMEOUT: set o_timeout, go to IDLE, set ptr = (o_grant+1) mod N.
  - The partial packet already emitted is not terminated.
  - Backpressure from i_tready does not count as a stall.
- Inputs that are not granted may change tvalid/tdata freely; the block never samples them except for the arbitration search.
- Changes on i_tvalid of non-granted inputs do not affect the current grant.

## Timing
- Reset values:
  - State IDLE, ptr 0, o_grant 0, o_busy 0, o_timeout 0, stall counter 0.
  - o_tvalid 0, o_tlast 0, o_tdata 0, o_tready all 0.
- Arbitration latency:
  - A request seen in IDLE at cycle t gives o_busy = 1 at t+1.
  - The first beat is accepted at t+1 if the output register can load.
  - The first beat appears on o_tvalid at t+2.
- Data latency: accepted input beat to o_tvalid is 1 cycle.
- Throughput:
  - 1 beat/cycle within a packet while i_tready = 1.
  - Exactly one idle cycle between packets: the IDLE cycle after tlast.
- rst asserted mid-packet discards the grant and the output register in the next cycle; no beat is emitted after reset until a new arbitration.
- A single-beat packet (tlast on its first beat) occupies LOCKED for exactly one accepting cycle.

## Test plan
- **Single source:** N=4, only input 2 sends 3 beats 0x41,0x42,0x43 with tlast on 0x43, i_tready = 1.
  - o_grant = 2.
  - Output 0x41,0x42,0x43 on consecutive cycles starting 2 cycles after tvalid rises, o_tlast on the third beat.
  - Then o_busy falls.
- **Fairness:** all four inputs continuously send 2-beat packets.
  - Grant order 0,1,2,3,0.
  - Each packet's two beats are contiguous on the output with no interleaving.
  - One bubble cycle between packets.
- **Backpressure:** i_tready toggles 1,0,0,1 during a 4-beat packet.
  - o_tdata is stable while o_tvalid && !i_tready.
  - No beat is lost or duplicated.
  - o_tready[grant] is low exactly when o_tvalid && !i_tready.
- **Watchdog:** TIMEOUT=8; input 1 sends one beat without tlast, then drops tvalid.
  - After 8 stall cycles o_timeout = 1 and the block returns to IDLE.
  - Input 2's pending packet is granted next.
  - o_timeout stays 1 until rst.
- **Reset mid-packet:** assert rst for one cycle during beat 2 of 4.
  - Next cycle all outputs are at reset values.
  - After rst, arbitration restarts from ptr = 0.
- **Simultaneous release and request:** input 3 finishes a packet on the cycle input 0 raises tvalid, with input 3 also still valid.
  - Next grant is 0, since ptr wraps to 0.
  - Input 3 is served only after input 0's packet completes.
